strobe_sequencer: RTL

Parametrised successor to the fixed three-rate pulse generator and 2-bit state machine pair. One clock, clock-enable style: no generated clocks. It produces debounce, fast and slow single-cycle strobes from programmable dividers. It also runs an N-state up/down sequencer that advances on the fast strobe, the slow strobe, or a debounced push-button step, chosen at run time by `mode`. It sits directly on the 2.5 MHz board clock and feeds the timing/selection logic.

---
 rtl/strobe_seq_pkg.sv | 18 +
 rtl/strobe_divider.sv | 34 +++
 rtl/strobe_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/strobe_seq_pkg.sv
// rtl/strobe_seq_pkg.sv - shared mode encoding and default divider constants for strobe_sequencer
package strobe_seq_pkg;

   typedef enum logic [1:0] {
      MODE_FAST = 2'd0,
      MODE_SLOW = 2'd1,
      MODE_STEP = 2'd2,
      MODE_HOLD = 2'd3
   } mode_t;

   // Defaults assume the 2.5 MHz board clock: 1 kHz, 10 Hz and 1 Hz strobes.
   localparam int DEFAULT_DIV_WIDTH    = 24;
   localparam int DEFAULT_DEBOUNCE_DIV = 2500;
   localparam int DEFAULT_FAST_DIV     = 250000;
   localparam int DEFAULT_SLOW_DIV     = 2500000;
   localparam int DEFAULT_NUM_STATES   = 4;

endpackage

// File: rtl/strobe_divider.sv
// rtl/strobe_divider.sv - clock-enable divider producing a one-cycle strobe every DIV enabled cycles
module strobe_divider #(
   parameter int DIV_WIDTH = 24,
   parameter int DIV       = 2500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic pulse
);

   localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIV - 1);

   logic [DIV_WIDTH-1:0] count;

   // The strobe is registered off the terminal count, so it appears the cycle after count = DIV-1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         pulse <= 1'b0;
      end else if (enable) begin
         if (count == LAST) begin
            count <= '0;
            pulse <= 1'b1;
         end else begin
            count <= count + DIV_WIDTH'(1);
            pulse <= 1'b0;
         end
      end else begin
         pulse <= 1'b0;
      end
   end

endmodule

// File: rtl/strobe_sequencer.sv
// rtl/strobe_sequencer.sv - three strobe dividers, push-button debounce and an N-state up/down sequencer
module strobe_sequencer
   import strobe_seq_pkg::*;
#(
   parameter int DIV_WIDTH    = DEFAULT_DIV_WIDTH,
   parameter int DEBOUNCE_DIV = DEFAULT_DEBOUNCE_DIV,
   parameter int FAST_DIV     = DEFAULT_FAST_DIV,
   parameter int SLOW_DIV     = DEFAULT_SLOW_DIV,
   parameter int NUM_STATES   = DEFAULT_NUM_STATES,
   localparam int STATE_W     = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [1:0]         mode,
   input  logic               direction,
   input  logic               step_req,
   output logic               debounce_pulse,
   output logic               fast_pulse,
   output logic               slow_pulse,
   output logic [STATE_W-1:0] state,
   output logic               wrap_pulse
);

   localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);

   logic [1:0] sync_ff;
   logic [2:0] history;
   logic [2:0] history_next;
   logic       level;
   logic       step_evt;
   logic       advance;
   mode_t      mode_sel;

   strobe_divider #(.DIV_WIDTH(DIV_WIDTH), .DIV(DEBOUNCE_DIV)) u_debounce_div (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pulse(debounce_pulse)
   );

   strobe_divider #(.DIV_WIDTH(DIV_WIDTH), .DIV(FAST_DIV)) u_fast_div (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pulse(fast_pulse)
   );

   strobe_divider #(.DIV_WIDTH(DIV_WIDTH), .DIV(SLOW_DIV)) u_slow_div (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pulse(slow_pulse)
   );

   assign history_next = {history[1:0], sync_ff[1]};

   // Level only moves on three agreeing samples; step_evt fires on its rising edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_ff  <= '0;
         history  <= '0;
         level    <= 1'b0;
         step_evt <= 1'b0;
      end else if (enable) begin
         sync_ff  <= {sync_ff[0], step_req};
         step_evt <= 1'b0;
         if (debounce_pulse) begin
            history <= history_next;
            if (history_next == 3'b111) begin
               level    <= 1'b1;
               step_evt <= ~level;
            end else if (history_next == 3'b000) begin
               level <= 1'b0;
            end
         end
      end else begin
         step_evt <= 1'b0;
      end
   end

   assign mode_sel = mode_t'(mode);

   always_comb begin
      advance = 1'b0;
      case (mode_sel)
         MODE_FAST: advance = fast_pulse;
         MODE_SLOW: advance = slow_pulse;
         MODE_STEP: advance = step_evt;
         default:   advance = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= '0;
         wrap_pulse <= 1'b0;
      end else if (enable && advance) begin
         if (direction) begin
            if (state == '0) begin
               state      <= LAST_STATE;
               wrap_pulse <= 1'b1;
            end else begin
               state      <= state - STATE_W'(1);
               wrap_pulse <= 1'b0;
            end
         end else begin
            if (state == LAST_STATE) begin
               state      <= '0;
               wrap_pulse <= 1'b1;
            end else begin
               state      <= state + STATE_W'(1);
               wrap_pulse <= 1'b0;
            end
         end
      end else begin
         wrap_pulse <= 1'b0;
      end
   end

endmodule
